// File: rtl/piso_tx_sched.sv
// -----------------------------------------------------------------------------
// piso_tx_sched
//
// Two-requester round-robin scheduler placed in front of a WIDTH-bit piso_dff.
// A winning word is captured and presented on piso_data together with a
// one-cycle piso_load strobe. The scheduler then times the WIDTH-cycle serial
// frame (frame_active), pulses done once the last bit has left, and inserts
// GAP_CYCLES idle cycles before the next request can be accepted.
//
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous reset, active low
//   req0 / req1  : request from source 0 / 1
//   data0 / data1: parallel word of source 0 / 1
//   gnt0 / gnt1  : one-cycle grant pulse, word has been captured
//   piso_load    : load strobe to piso_dff
//   piso_data    : parallel word to piso_dff
//   frame_active : high while serial_out carries frame bits
//   grant_id     : owner of the current or last frame
//   done         : one-cycle pulse after the last frame bit
//   o_dbg_state  : current FSM state (debug observation)
//
// Handshake: a source raises reqN and holds dataN stable until it sees gntN
// high; it drops reqN in that same cycle. gntN means dataN was captured at the
// edge that raised gntN. Requests are only sampled in IDLE; a request raised
// while a frame is loading, shifting or in its gap simply waits until IDLE.
//
// Timing from the sampling edge t (IDLE, any req high):
//   cycle t+1            : LOAD, piso_load=1, gnt pulse
//   cycles t+2..t+1+WIDTH: SHIFT, frame_active=1
//   cycle t+2+WIDTH      : done=1 (GAP, or IDLE when GAP_CYCLES=0)
// -----------------------------------------------------------------------------
module piso_tx_sched #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             piso_load,
  output logic [WIDTH-1:0] piso_data,
  output logic             frame_active,
  output logic             grant_id,
  output logic             done,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam bit            HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [3:0]    GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_gnt0, r_gnt1, r_load, r_fa, r_done, r_id, r_last_id;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_gap;

  logic             w_gnt0_nxt, w_gnt1_nxt, w_load_nxt, w_fa_nxt, w_done_nxt;
  logic             w_id_nxt, w_last_id_nxt, w_win;
  logic [WIDTH-1:0] w_data_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [3:0]       w_gap_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt0_nxt    = 1'b0;
    w_gnt1_nxt    = 1'b0;
    w_load_nxt    = 1'b0;
    w_fa_nxt      = 1'b0;
    w_done_nxt    = 1'b0;
    w_id_nxt      = r_id;
    w_last_id_nxt = r_last_id;
    w_data_nxt    = r_data;
    w_cnt_nxt     = r_cnt;
    w_gap_nxt     = r_gap;
    w_win         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          // On a tie the source that did not win the last tie goes next;
          // a lone request wins outright and leaves the pointer untouched.
          if (req0 && req1) begin
            w_win         = ~r_last_id;
            w_last_id_nxt = ~r_last_id;
          end else begin
            w_win = req1;
          end
          w_data_nxt  = w_win ? data1 : data0;
          w_id_nxt    = w_win;
          w_gnt0_nxt  = ~w_win;
          w_gnt1_nxt  = w_win;
          w_load_nxt  = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end

      ST_LOAD: begin
        w_cnt_nxt   = '0;
        w_fa_nxt    = 1'b1;
        w_state_nxt = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (r_cnt == CNT_LAST) begin
          w_done_nxt  = 1'b1;
          w_gap_nxt   = '0;
          w_state_nxt = HAS_GAP ? ST_GAP : ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          w_fa_nxt  = 1'b1;
        end
      end

      ST_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap + 4'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_load    <= 1'b0;
      r_fa      <= 1'b0;
      r_done    <= 1'b0;
      r_id      <= 1'b0;
      r_last_id <= 1'b1;
      r_data    <= '0;
      r_cnt     <= '0;
      r_gap     <= '0;
    end else begin
      r_gnt0    <= w_gnt0_nxt;
      r_gnt1    <= w_gnt1_nxt;
      r_load    <= w_load_nxt;
      r_fa      <= w_fa_nxt;
      r_done    <= w_done_nxt;
      r_id      <= w_id_nxt;
      r_last_id <= w_last_id_nxt;
      r_data    <= w_data_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gap     <= w_gap_nxt;
    end
  end

  assign gnt0         = r_gnt0;
  assign gnt1         = r_gnt1;
  assign piso_load    = r_load;
  assign piso_data    = r_data;
  assign frame_active = r_fa;
  assign grant_id     = r_id;
  assign done         = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_piso_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_piso_tx_sched
//
// Two instances: GAP_CYCLES=1 (index 0) and GAP_CYCLES=0 (index 1), each with
// its own requesters. A frame-level reference model predicts, per cycle, the
// grant/load/frame/done windows from the load cycle L of the last accepted
// request. A behavioural PISO checks the serial bit order, and a queue of
// expected {id, word} pairs is matched against every observed grant.
// -----------------------------------------------------------------------------
module tb_piso_tx_sched;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT signals ----------------
  logic         req0_a [2];
  logic         req1_a [2];
  logic [W-1:0] d0_a   [2];
  logic [W-1:0] d1_a   [2];
  logic         gnt0_w [2];
  logic         gnt1_w [2];
  logic         load_w [2];
  logic         fa_w   [2];
  logic         id_w   [2];
  logic         done_w [2];
  logic [W-1:0] pd_w   [2];
  logic [1:0]   dbg_w  [2];

  piso_tx_sched #(.WIDTH(W), .GAP_CYCLES(1)) u_dut_g1 (
    .clk(clk), .rst(rst),
    .req0(req0_a[0]), .data0(d0_a[0]), .req1(req1_a[0]), .data1(d1_a[0]),
    .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .piso_load(load_w[0]),
    .piso_data(pd_w[0]), .frame_active(fa_w[0]), .grant_id(id_w[0]),
    .done(done_w[0]), .o_dbg_state(dbg_w[0])
  );

  piso_tx_sched #(.WIDTH(W), .GAP_CYCLES(0)) u_dut_g0 (
    .clk(clk), .rst(rst),
    .req0(req0_a[1]), .data0(d0_a[1]), .req1(req1_a[1]), .data1(d1_a[1]),
    .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .piso_load(load_w[1]),
    .piso_data(pd_w[1]), .frame_active(fa_w[1]), .grant_id(id_w[1]),
    .done(done_w[1]), .o_dbg_state(dbg_w[1])
  );

  // ---------------- reference model state ----------------
  int           n_total = 0;
  int           n_bad   = 0;
  int           e       = 0;       // index of the cycle following the latest edge
  int           last_load   [2];   // cycle in which piso_load/gnt of the last frame is high
  int           next_sample [2];   // first edge at which a request may be accepted
  bit           m_last_id   [2];
  bit           m_id        [2];
  logic [W-1:0] m_data      [2];
  logic [W-1:0] sr          [2];   // behavioural piso_dff
  logic         pl_s        [2];
  logic [W-1:0] pd_s        [2];
  logic [W:0]   exp_q0[$];
  logic [W:0]   exp_q1[$];

  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic sb_check_gnt(input int d, input logic [W:0] obs);
    logic [31:0] want;
    want = 32'hDEAD_BEEF;
    if (d == 0) begin
      if (exp_q0.size() != 0) want = 32'(exp_q0.pop_front());
    end else begin
      if (exp_q1.size() != 0) want = 32'(exp_q1.pop_front());
    end
    check($sformatf("d%0d sb_grant_word", d), 32'(obs), want);
  endtask

  // ---------------- model ----------------
  task automatic model_edge(input int d);
    bit w;
    if (!rst) begin
      last_load[d]   = -1000;
      next_sample[d] = e + 1;
      m_last_id[d]   = 1'b1;
      m_id[d]        = 1'b0;
      m_data[d]      = '0;
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
    end else if (e >= next_sample[d] && (req0_a[d] || req1_a[d])) begin
      if (req0_a[d] && req1_a[d]) begin
        w = ~m_last_id[d];
        m_last_id[d] = w;
      end else begin
        w = req1_a[d];
      end
      m_id[d]        = w;
      m_data[d]      = w ? d1_a[d] : d0_a[d];
      last_load[d]   = e;
      next_sample[d] = e + W + 2 + gap_of(d);
      if (d == 0) exp_q0.push_back({w, m_data[d]});
      else        exp_q1.push_back({w, m_data[d]});
    end
  endtask

  task automatic check_cycle(input int d);
    int  l;
    bit  in_frame;
    int  idx;
    l        = last_load[d];
    in_frame = (e >= l + 1) && (e <= l + W);
    check($sformatf("d%0d gnt0", d), 32'(gnt0_w[d]), 32'((e == l) && !m_id[d]));
    check($sformatf("d%0d gnt1", d), 32'(gnt1_w[d]), 32'((e == l) && m_id[d]));
    check($sformatf("d%0d piso_load", d), 32'(load_w[d]), 32'(e == l));
    check($sformatf("d%0d frame_active", d), 32'(fa_w[d]), 32'(in_frame));
    check($sformatf("d%0d done", d), 32'(done_w[d]), 32'(e == l + W + 1));
    check($sformatf("d%0d piso_data", d), 32'(pd_w[d]), 32'(m_data[d]));
    check($sformatf("d%0d grant_id", d), 32'(id_w[d]), 32'(m_id[d]));
    check($sformatf("d%0d gnt_exclusive", d), 32'(gnt0_w[d] & gnt1_w[d]), 32'd0);
    check($sformatf("d%0d load_vs_frame", d), 32'(load_w[d] & fa_w[d]), 32'd0);
    if (in_frame) begin
      idx = W - (e - l);
      check($sformatf("d%0d serial_bit", d), 32'(sr[d][W-1]), 32'(m_data[d][idx]));
    end
    if (gnt0_w[d] || gnt1_w[d]) sb_check_gnt(d, {gnt1_w[d], pd_w[d]});
  endtask

  // ---------------- driver ----------------
  // p0/p1: percent chance per cycle that an idle requester raises its request.
  task automatic tick(input bit rst_v, input int p0, input int p1, input bit rnd);
    @(negedge clk);
    rst = rst_v;
    for (int d = 0; d < 2; d++) begin
      pl_s[d] = load_w[d];
      pd_s[d] = pd_w[d];
      if (gnt0_w[d]) req0_a[d] = 1'b0;
      else if (!req0_a[d] && int'($urandom_range(99)) < p0) begin
        req0_a[d] = 1'b1;
        d0_a[d]   = rnd ? W'($urandom) : W'(4'b0001);
      end
      if (gnt1_w[d]) req1_a[d] = 1'b0;
      else if (!req1_a[d] && int'($urandom_range(99)) < p1) begin
        req1_a[d] = 1'b1;
        d1_a[d]   = rnd ? W'($urandom) : W'(4'b1110);
      end
    end
    @(posedge clk);
    e++;
    for (int d = 0; d < 2; d++) begin
      sr[d] = pl_s[d] ? pd_s[d] : (sr[d] << 1);
      model_edge(d);
    end
    #1;
    for (int d = 0; d < 2; d++) check_cycle(d);
  endtask

  task automatic raise(input int d, input bit which, input logic [W-1:0] v);
    if (which) begin
      req1_a[d] = 1'b1;
      d1_a[d]   = v;
    end else begin
      req0_a[d] = 1'b1;
      d0_a[d]   = v;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req0_a[d] = 1'b0; req1_a[d] = 1'b0;
      d0_a[d] = '0; d1_a[d] = '0;
      sr[d] = '0; pl_s[d] = 1'b0; pd_s[d] = '0;
      last_load[d] = -1000; next_sample[d] = 0;
      m_last_id[d] = 1'b1; m_id[d] = 1'b0; m_data[d] = '0;
    end

    // Reset, then idle with no requests
    repeat (2) tick(1'b0, 0, 0, 1'b0);
    repeat (10) tick(1'b1, 0, 0, 1'b0);

    // Single request of 1011
    for (int d = 0; d < 2; d++) raise(d, 1'b0, 4'b1011);
    repeat (12) tick(1'b1, 0, 0, 1'b0);

    // Both requesters continuously requesting: 0001 / 1110 alternate
    repeat (40) tick(1'b1, 100, 100, 1'b0);
    repeat (20) tick(1'b1, 0, 0, 1'b0);

    // Request 1 raised during the shift phase of a request 0 frame
    for (int d = 0; d < 2; d++) raise(d, 1'b0, 4'b0110);
    repeat (3) tick(1'b1, 0, 0, 1'b0);
    for (int d = 0; d < 2; d++) raise(d, 1'b1, 4'b1001);
    repeat (20) tick(1'b1, 0, 0, 1'b0);

    // Reset during the third shift cycle, then a tie after release
    for (int d = 0; d < 2; d++) raise(d, 1'b0, 4'b1100);
    repeat (4) tick(1'b1, 0, 0, 1'b0);
    tick(1'b0, 0, 0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      raise(d, 1'b0, 4'b0011);
      raise(d, 1'b1, 4'b0101);
    end
    repeat (20) tick(1'b1, 0, 0, 1'b0);

    // Back-to-back requests from source 0 only
    repeat (30) tick(1'b1, 100, 0, 1'b0);
    repeat (15) tick(1'b1, 0, 0, 1'b0);

    // Randomized traffic with occasional resets
    repeat (3000) tick(($urandom_range(199) != 0), 30, 30, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
